// File: rtl/bcd_stopwatch_display.sv
// N-digit BCD stopwatch (hold/up/down/load) with multiplexed 7-segment drive.
// Optional leading-zero blanking: define BCD_STOPWATCH_BLANK_EN.
module bcd_stopwatch_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            s,
  input  logic [4*DIGITS-1:0]   set,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  mode_t                 mode;
  logic [PRE_W-1:0]      pre;
  logic [SCN_W-1:0]      scan_pre;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic [4*DIGITS-1:0]   up_val;
  logic [4*DIGITS-1:0]   dn_val;
  logic [4*DIGITS-1:0]   load_val;
  logic                  up_wrap;
  logic                  dn_wrap;
  logic [3:0]            cur;
  logic                  cur_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    mode = mode_t'(s);
    tick = ((mode == MODE_UP) || (mode == MODE_DOWN)) && (pre == PRE_LAST);
  end

  // Ripple carry/borrow through the digits; surviving carry/borrow marks the wrap.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    up_val   = '0;
    dn_val   = '0;
    load_val = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) up_val[4*i +: 4] = 4'd0;
        else begin
          up_val[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end else begin
        up_val[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) dn_val[4*i +: 4] = 4'd9;
        else begin
          dn_val[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dn_val[4*i +: 4] = d;
      end
      load_val[4*i +: 4] = (set[4*i +: 4] > 4'd9) ? 4'd9 : set[4*i +: 4];
    end
    up_wrap = carry;
    dn_wrap = borrow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre   <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (mode)
        MODE_LOAD: begin
          pre   <= '0;
          count <= load_val;
        end
        MODE_UP, MODE_DOWN: begin
          if (tick) begin
            pre   <= '0;
            count <= (mode == MODE_UP) ? up_val : dn_val;
            wrap  <= (mode == MODE_UP) ? up_wrap : dn_wrap;
          end else begin
            pre <= pre + PRE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_pre <= '0;
      idx      <= '0;
    end else if (scan_pre == SCN_LAST) begin
      scan_pre <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_pre <= scan_pre + SCN_W'(1);
    end
  end

  always_comb begin
    cur = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur = count[4*i +: 4];
    end
  end

`ifdef BCD_STOPWATCH_BLANK_EN
  // blank[i]: digit i and every more-significant digit are zero; digit 0 never blanks.
  logic [DIGITS-1:0] blank;
  always_comb begin
    logic lead;
    int unsigned j;
    blank = '0;
    lead  = 1'b1;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      j = DIGITS - 1 - k;
      lead = lead && (count[4*j +: 4] == 4'd0);
      blank[j] = lead;
    end
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_blank = blank[i];
    end
  end
`else
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'b0111111;
      an  <= DIGITS'(1);
    end else begin
      seg <= cur_blank ? 7'b0000000 : decode(cur);
      an  <= DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_display.sv
// Scoreboard bench for bcd_stopwatch_display: decimal-value reference model,
// directed scenarios followed by randomized mode/load/reset traffic.
module tb_bcd_stopwatch_display;

  localparam int D    = 2;
  localparam int TDIV = 2;
  localparam int SDIV = 1;
  localparam int MAXV = 100;

  logic             clk;
  logic             reset;
  logic [1:0]       s;
  logic [4*D-1:0]   set;
  logic [4*D-1:0]   count;
  logic             wrap;
  logic [6:0]       seg;
  logic [D-1:0]     an;

  bcd_stopwatch_display #(
    .DIGITS  (D),
    .TICK_DIV(TDIV),
    .SCAN_DIV(SDIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s    (s),
    .set  (set),
    .count(count),
    .wrap (wrap),
    .seg  (seg),
    .an   (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] count;
    logic           wrap;
    logic [6:0]     seg;
    logic [D-1:0]   an;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   wraps_seen = 0;

  // Reference state: the count as a plain decimal integer
  int m_val, m_pre, m_scan, m_idx;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t [10];
    t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    return t[d];
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  task automatic model_step(input logic r, input logic [1:0] sv, input logic [4*D-1:0] st);
    exp_t e;
    int   dig;
    int   nib;
    bit   blank;
    if (r) begin
      m_val = 0; m_pre = 0; m_scan = 0; m_idx = 0;
      e.count = '0; e.wrap = 1'b0; e.seg = seg_of(0); e.an = D'(1);
      q.push_back(e);
      return;
    end
    dig   = (m_val / pow10(m_idx)) % 10;
`ifdef BCD_STOPWATCH_BLANK_EN
    blank = (m_idx > 0) && (m_val < pow10(m_idx));
`else
    blank = 1'b0;
`endif
    e.seg = blank ? 7'b0000000 : seg_of(dig);
    e.an  = D'(1) << m_idx;
    if (m_scan == SDIV - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % D;
    end else begin
      m_scan++;
    end
    e.wrap = 1'b0;
    case (sv)
      2'b11: begin
        m_pre = 0;
        m_val = 0;
        for (int k = 0; k < D; k++) begin
          nib = int'(st[4*k +: 4]);
          if (nib > 9) nib = 9;
          m_val += nib * pow10(k);
        end
      end
      2'b01, 2'b10: begin
        if (m_pre == TDIV - 1) begin
          m_pre = 0;
          if (sv == 2'b01) begin
            e.wrap = (m_val == MAXV - 1);
            m_val  = (m_val + 1) % MAXV;
          end else begin
            e.wrap = (m_val == 0);
            m_val  = (m_val + MAXV - 1) % MAXV;
          end
        end else begin
          m_pre++;
        end
      end
      default: ;
    endcase
    e.count = to_bcd(m_val);
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [1:0] sv, input logic [4*D-1:0] st, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = r; s = sv; set = st;
      model_step(r, sv, st);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
  endtask

  // Monitor: every cycle the DUT presents registered outputs, compare against queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", 32'(count), 32'(e.count));
        chk("wrap",  32'(wrap),  32'(e.wrap));
        chk("seg",   32'(seg),   32'(e.seg));
        chk("an",    32'(an),    32'(e.an));
        if (e.wrap) wraps_seen++;
      end
    end
  end

  initial begin
    int r;
    logic [1:0] sv;
    reset = 1'b1; s = 2'b00; set = '0;
    m_val = 0; m_pre = 0; m_scan = 0; m_idx = 0;

    step(1'b1, 2'b00, 8'h00, 2);
    step(1'b0, 2'b00, 8'h00, 4);          // idle after reset: an alternates
    step(1'b0, 2'b11, 8'h98, 1);          // load 98
    step(1'b0, 2'b01, 8'h00, 6);          // 98 -> 99 -> 00 (wrap) -> 01
    step(1'b1, 2'b00, 8'h00, 1);
    step(1'b0, 2'b10, 8'h00, 5);          // 00 -> 99 (wrap) -> 98
    step(1'b0, 2'b11, 8'hC5, 1);          // clamps to 95
    step(1'b0, 2'b00, 8'h00, 10);         // hold
    step(1'b0, 2'b01, 8'h00, 3);          // pre ends at 1
    step(1'b0, 2'b00, 8'h00, 3);
    step(1'b0, 2'b01, 8'h00, 3);          // tick on first counting cycle
    step(1'b0, 2'b10, 8'h00, 3);          // direction change keeps pre
    step(1'b0, 2'b11, 8'h05, 1);
    step(1'b0, 2'b00, 8'h05, 4);          // digit-1 slot of 05
    step(1'b0, 2'b11, 8'h00, 1);
    step(1'b0, 2'b00, 8'h00, 4);
    step(1'b0, 2'b11, 8'hFF, 1);          // both nibbles clamp to 99
    step(1'b0, 2'b01, 8'h00, 3);

    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      sv = 2'b11;
      else if (r < 30) sv = 2'b00;
      else if (r < 65) sv = 2'b01;
      else             sv = 2'b10;
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, sv, 8'($urandom), $urandom_range(1, 12));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected responses left unchecked, required 0", q.size());
    checks++;
    if (wraps_seen > 0) passes++;
    else $display("FAIL wrap_coverage: got %0d expected wrap pulses, required >0", wraps_seen);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_stopwatch_display.md
# bcd_stopwatch_display

Parametrised N-digit BCD stopwatch core with time-multiplexed 7-segment drive. It integrates the prescaler, the up/down/hold/load counter and the segment decoder into one block, driving a common segment bus with one-hot digit enables. It sits between the board switch/button inputs and the 7-segment display pins.

## Interface
- DIGITS, 4, number of BCD digits (1–8); digit 0 is least significant
- TICK_DIV, 50000, clk cycles per count tick (≥1)
- SCAN_DIV, 1000, clk cycles per display digit slot (≥1)
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- s  input  2  mode: 00 hold, 01 count up, 10 count down, 11 load
- set  input  4*DIGITS  load value, nibble i → digit i
- count  output  4*DIGITS  current BCD value, registered
- wrap  output  1  one-cycle pulse on terminal wrap
- seg  output  7  segments gfedcba, active-high, registered
- an  output  DIGITS  one-hot digit enable, active-high, registered

## Operation
- Prescaler `pre` (0..TICK_DIV-1): increments while s=01 or 10; holds while s=00; cleared by s=11 and by reset. Tick = (s∈{01,10}) && pre==TICK_DIV-1; pre returns to 0 on tick.
- Counter update on tick:
  - Up: digit 0 +1; digit at 9 → 0 with carry into next digit. All-9s → all-0s, wrap=1 for that cycle.
  - Down: digit 0 −1; digit at 0 → 9 with borrow. All-0s → all-9s, wrap=1.
- Load (s=11): every cycle, count ← set; nibbles >9 clamp to 9. No tick, no wrap.
- Priority: reset > load > tick > hold.
- Mode change 01↔10 keeps pre; next tick counts in the new direction.
- Scan: free-running scan prescaler (0..SCAN_DIV-1) and digit index (0..DIGITS-1), independent of s. Index advances when scan prescaler hits SCAN_DIV-1; DIGITS-1 → 0.
- Decode (gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; blank=0000000.
- seg/an registered from the current index and count; an = 1<<index.

## Timing
- Reset values: count=0, wrap=0, pre=0, scan prescaler=0, index=0, an=…0001, seg=0111111.
- Tick latency: count changes on the edge where the tick condition is true; new value visible on count the following cycle. wrap is asserted in that same cycle only.
- Load latency: count=clamp(set) one cycle after s=11 is sampled.
- Display latency: seg/an reflect index and count one cycle after they change. Worst-case display lag is SCAN_DIV*DIGITS+1 cycles.
- Count period: one step every TICK_DIV cycles of uninterrupted counting. Hold pauses, does not discard, the partial period.
- Reset mid-count or mid-scan: all state returns to its reset value on the next edge.
- TICK_DIV=1: ticks every cycle while counting. SCAN_DIV=1: index advances every cycle.

## Configuration
- `BCD_STOPWATCH_BLANK_EN` defined:
  - Leading-zero digits are blanked (seg=0000000).
  - A digit i>0 is blanked when it and all more-significant digits are 0.
  - Digit 0 is never blanked.
  - an still cycles normally.
- Not defined: every digit is always decoded, including leading zeros.

## Test plan
- Reset release (DIGITS=2, TICK_DIV=2, SCAN_DIV=1) → count=00, an=01, seg=0111111, wrap=0; then an alternates 01/10 every cycle.
- Load set=0x98, then s=01 → count 98→99→00 at 2-cycle spacing; wrap=1 for exactly one cycle coincident with 00.
- Reset, s=10 → after 2 cycles count=99, wrap pulse; next tick → 98.
- s=11 with set=0xC5 → count=95 after one cycle, wrap=0; s=00 for 10 cycles → count stays 95.
- Count up, then s=00 mid-period with pre=1, then s=01 → next tick one cycle later (pre preserved).
- With the macro, count=05 → digit-1 slot shows seg=0000000; count=00 → digit 0 shows 0111111. Without the macro, the digit-1 slot shows 0111111.
